// File: rtl/gf2_pkg.sv
// Shared constants, FSM state type and degree helper for the GF(2) polynomial divider.
package gf2_pkg;

   // Divisor field width and the dividend width of a full product (2*M-1).
   localparam int M  = 3;
   localparam int PW = 2 * M - 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   // Degree of a nonzero divisor polynomial; a zero divisor reports 0 and is
   // screened out before this value is ever used.
   function automatic logic [1:0] deg_of(input logic [M-1:0] p);
      if (p[2])
         return 2'd2;
      else if (p[1])
         return 2'd1;
      else
         return 2'd0;
   endfunction

endpackage

// File: rtl/gf2_poly_div.sv
// Sequential GF(2) polynomial divider: 5-bit dividend by 3-bit divisor.
//
// Handshake: Start is a request that is only looked at while IDLE; D and B are
// captured on that same edge. There is no backpressure. Completion is a single
// cycle Done pulse, and Q/R/Err are valid from that cycle and hold until the
// next Done. Start raised while CALC or DONE is dropped, not queued.
//
// Each CALC cycle examines one dividend bit, from x^4 down to x^0, so the
// operation always takes five CALC cycles whatever the divisor degree.
module gf2_poly_div
   import gf2_pkg::*;
(
   input  logic          Clk,
   input  logic          Rst,
   input  logic          Start,
   input  logic [PW-1:0] D,
   input  logic [M-1:0]  B,
   output logic [PW-1:0] Q,
   output logic [M-2:0]  R,
   output logic          Busy,
   output logic          Done,
   output logic          Err,
   output state_t        fsm_state
);

   state_t        state;
   state_t        state_next;
   logic [PW-1:0] w;          // working remainder
   logic [PW-1:0] qw;         // working quotient
   logic [M-1:0]  bw;         // latched divisor
   logic [1:0]    dbw;        // latched divisor degree
   logic [2:0]    cnt;        // bit position examined this CALC cycle
   logic [2:0]    shift;
   logic [PW-1:0] w_step;
   logic [PW-1:0] qw_step;

   assign fsm_state = state;

   // State register.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next-state decode and the Busy/Done status outputs.
   always_comb begin
      state_next = state;
      Busy       = 1'b0;
      Done       = 1'b0;
      case (state)
         IDLE: begin
            if (Start)
               state_next = (B == '0) ? DONE : CALC;
         end
         CALC: begin
            Busy = 1'b1;
            if (cnt == 3'd0)
               state_next = DONE;
         end
         DONE: begin
            Done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // One long-division step: cancel bit cnt with the divisor aligned under it.
   always_comb begin
      shift   = cnt - {1'b0, dbw};
      w_step  = w;
      qw_step = qw;
      if ((cnt >= {1'b0, dbw}) && w[cnt]) begin
         w_step  = w ^ (PW'(bw) << shift);
         qw_step = qw | (PW'(1) << shift);
      end
   end

   // Working registers and the held result outputs.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         w   <= '0;
         qw  <= '0;
         bw  <= '0;
         dbw <= '0;
         cnt <= '0;
         Q   <= '0;
         R   <= '0;
         Err <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (Start) begin
                  if (B != '0) begin
                     w   <= D;
                     bw  <= B;
                     dbw <= deg_of(B);
                     qw  <= '0;
                     cnt <= 3'(PW - 1);
                  end else begin
                     Q   <= '0;
                     R   <= '0;
                     Err <= 1'b1;
                  end
               end
            end
            CALC: begin
               w  <= w_step;
               qw <= qw_step;
               if (cnt == 3'd0) begin
                  Q   <= qw_step;
                  R   <= w_step[M-2:0];
                  Err <= 1'b0;
               end else begin
                  cnt <= cnt - 3'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_gf2_poly_div.sv
// Self-checking bench for gf2_poly_div against a polynomial long-division model.
module tb_gf2_poly_div;
   import gf2_pkg::*;

   logic       Clk = 1'b0;
   logic       Rst;
   logic       Start;
   logic [4:0] D;
   logic [2:0] B;
   logic [4:0] Q;
   logic [1:0] R;
   logic       Busy;
   logic       Done;
   logic       Err;
   state_t     fsm_state;

   int passed = 0;
   int total  = 0;
   int last_q = 0;
   int last_r = 0;
   int last_e = 0;

   gf2_poly_div dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .Start     (Start),
      .D         (D),
      .B         (B),
      .Q         (Q),
      .R         (R),
      .Busy      (Busy),
      .Done      (Done),
      .Err       (Err),
      .fsm_state (fsm_state)
   );

   // Clock.
   always #5 Clk = ~Clk;

   // Watchdog so the run can never hang.
   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Highest set coefficient, -1 for the zero polynomial.
   function automatic int poly_deg(input int p);
      int d = -1;
      for (int i = 0; i < 32; i++)
         if (p[i]) d = i;
      return d;
   endfunction

   // Carry-free product.
   function automatic int clmul(input int a, input int b);
      int r = 0;
      for (int i = 0; i < 8; i++)
         if (b[i]) r = r ^ (a << i);
      return r;
   endfunction

   // Textbook long division: keep cancelling the leading term of the remainder.
   function automatic void ref_div(input int d, input int b, output int q, output int r);
      int db = poly_deg(b);
      q = 0;
      r = d;
      while (r != 0 && poly_deg(r) >= db) begin
         int s;
         s = poly_deg(r) - db;
         r = r ^ (b << s);
         q = q | (1 << s);
      end
   endfunction

   // One request; checks latency, busy, results and the single-cycle Done.
   task automatic run_op(input logic [4:0] d, input logic [2:0] b, input string tag);
      int eq, er, ee, lat;
      if (b == 3'b000) begin
         eq = 0; er = 0; ee = 1;
      end else begin
         ref_div(int'(d), int'(b), eq, er);
         ee = 0;
      end
      @(negedge Clk);
      Start = 1'b1; D = d; B = b;
      @(negedge Clk);
      Start = 1'b0; D = 5'($urandom); B = 3'($urandom);
      if (b != 3'b000) check({tag, " busy"}, 32'(Busy), 1);
      lat = 0;
      while (!Done && lat < 20) begin
         @(negedge Clk);
         lat++;
      end
      check({tag, " latency"}, lat, (b == 3'b000) ? 0 : 5);
      check({tag, " q"}, 32'(Q), eq);
      check({tag, " r"}, 32'(R), er);
      check({tag, " err"}, 32'(Err), ee);
      check({tag, " busy_at_done"}, 32'(Busy), 0);
      @(negedge Clk);
      check({tag, " done_pulse"}, 32'(Done), 0);
      last_q = eq; last_r = er; last_e = ee;
   endtask

   initial begin
      logic [4:0] ds [0:20];
      logic [2:0] bs [0:20];
      int eq, er;

      Rst = 1'b1; Start = 1'b0; D = '0; B = '0;
      repeat (2) @(negedge Clk);
      check("reset q", 32'(Q), 0);
      check("reset r", 32'(R), 0);
      check("reset err", 32'(Err), 0);
      check("reset busy", 32'(Busy), 0);
      check("reset done", 32'(Done), 0);
      check("reset state", 32'(fsm_state), 32'(IDLE));
      Rst = 1'b0;

      // Directed cases with hand-computed results.
      run_op(5'b01111, 3'b011, "dir1");
      check("dir1 q literal", 32'(Q), 32'b00101);
      run_op(5'b10000, 3'b111, "dir2");
      check("dir2 q literal", 32'(Q), 32'b00110);
      check("dir2 r literal", 32'(R), 32'b10);
      run_op(5'b10110, 3'b001, "dir3");
      check("dir3 q literal", 32'(Q), 32'b10110);
      run_op(5'b10110, 3'b000, "divzero");
      check("divzero err literal", 32'(Err), 1);
      run_op(5'b00111, 3'b010, "after_err");

      // Start held high with D/B changing every cycle.
      for (int k = 0; k <= 20; k++) begin
         ds[k] = 5'($urandom);
         bs[k] = 3'($urandom_range(1, 7));
         Start = 1'b1; D = ds[k]; B = bs[k];
         @(negedge Clk);
         if (k % 7 == 5) begin
            ref_div(int'(ds[k-5]), int'(bs[k-5]), eq, er);
            check("hold done", 32'(Done), 1);
            check("hold q", 32'(Q), eq);
            check("hold r", 32'(R), er);
            last_q = eq; last_r = er;
         end else begin
            check("hold no_done", 32'(Done), 0);
            check("hold q_kept", 32'(Q), last_q);
            check("hold r_kept", 32'(R), last_r);
         end
      end
      Start = 1'b0;
      repeat (2) @(negedge Clk);

      // Reset during the third CALC cycle.
      run_op(5'b10000, 3'b111, "pre_rst");
      @(negedge Clk);
      Start = 1'b1; D = 5'b10110; B = 3'b011;
      @(negedge Clk);
      Start = 1'b0;
      repeat (2) @(negedge Clk);
      check("mid busy", 32'(Busy), 1);
      Rst = 1'b1;
      #1;
      check("abort q", 32'(Q), 0);
      check("abort r", 32'(R), 0);
      check("abort err", 32'(Err), 0);
      check("abort busy", 32'(Busy), 0);
      check("abort done", 32'(Done), 0);
      check("abort state", 32'(fsm_state), 32'(IDLE));
      @(negedge Clk);
      Rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge Clk);
         check("abort no_done", 32'(Done), 0);
      end
      run_op(5'b01111, 3'b011, "post_rst");
      check("post_rst q literal", 32'(Q), 32'b00101);

      // Exact products divide cleanly.
      for (int a = 0; a < 8; a++) begin
         for (int bb = 1; bb < 8; bb++) begin
            run_op(5'(clmul(a, bb)), 3'(bb), "prod");
            check("prod q_is_a", 32'(Q), a);
            check("prod r_zero", 32'(R), 0);
         end
      end

      // Random operands, including zero divisors.
      for (int n = 0; n < 40; n++)
         run_op(5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), "rand");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/gf2_poly_div.md
GF2_POLY_DIV -- requirements
Module: gf2_poly_div

Interface
REQ-001 SHALL have parameter-free ports; widths fixed: dividend 5 bits, divisor 3 bits, GF(2) polynomial coefficients, bit i = coefficient of x^i.
REQ-002 Clk  input  1  single clock, all state on rising edge.
REQ-003 Rst  input  1  reset, asynchronous, active-high.
REQ-004 Start  input  1  request; sampled only in IDLE.
REQ-005 D  input  5  dividend polynomial, sampled with Start.
REQ-006 B  input  3  divisor polynomial, sampled with Start.
REQ-007 Q  output  5  quotient, registered.
REQ-008 R  output  2  remainder, registered; deg(R) < deg(B).
REQ-009 Busy  output  1  high while in CALC.
REQ-010 Done  output  1  one-cycle pulse; Q/R/Err valid from this cycle.
REQ-011 Err  output  1  divide-by-zero flag, registered.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE.
REQ-013 IDLE, Start=1, B!=0: latch D into working remainder W[4:0], B and deg(B) (2 if B[2], else 1 if B[1], else 0), clear working quotient, cnt=4, go CALC.
REQ-014 IDLE, Start=1, B=0: go DONE directly; Q=0, R=0, Err=1 at that edge.
REQ-015 CALC, each cycle with step i=cnt: if W[i]=1 and i>=deg(B), W ^= B<<(i-deg(B)) and set quotient bit (i-deg(B)); else no change; cnt decrements.
REQ-016 CALC always lasts exactly 5 cycles (cnt 4..0) regardless of deg(B); at the cnt=0 edge go DONE, load Q=quotient, R=W[1:0], Err=0.
REQ-017 Latency: Start sampled at edge t0 -> Done high from edge t0+5 to t0+6 (B!=0); from t0 to t0+1 (B=0).
REQ-018 DONE lasts one cycle, then IDLE unconditionally; Start during DONE or CALC SHALL be ignored (no queueing).
REQ-019 Busy=1 exactly in CALC; Done=1 exactly in DONE.
REQ-020 Q, R, Err SHALL hold their values from DONE until the next DONE; D/B changes outside the Start cycle have no effect.
REQ-021 Arithmetic is carry-free: addition/subtraction = XOR; no integer arithmetic on coefficients.

Reset
REQ-022 Rst=1 SHALL immediately force state IDLE, Q=0, R=0, Err=0, Busy=0, Done=0, cnt=0, working registers 0.
REQ-023 Rst asserted mid-CALC SHALL abort the operation; no Done pulse after release; first Start after release processed normally.

Structure
REQ-024 Shared package gf2_pkg SHALL hold: field/dividend width constants (M=3, PW=2*M-1), FSM state enum type, degree helper function.
REQ-025 Single module, no sub-module; one iteration step is combinational logic inside the block.

Verification
REQ-026 D=5'b01111, B=3'b011, Start 1 cycle -> Done 5 cycles later, Q=5'b00101, R=2'b00, Err=0.
REQ-027 D=5'b10000, B=3'b111 -> Q=5'b00110, R=2'b10, Err=0.
REQ-028 D=5'b10110, B=3'b001 -> Q=5'b10110, R=2'b00; B=3'b000 -> Done next cycle, Q=0, R=0, Err=1.
REQ-029 Start held high continuously with changing D/B -> only IDLE-cycle samples processed, one Done per 7 cycles, prior results held between.
REQ-030 Rst pulse at 3rd CALC cycle -> all outputs 0 immediately, no Done; next Start with D=5'b01111,B=3'b011 gives Q=5'b00101.
REQ-031 Exhaustive: all A in 0..7, B in 1..7, D = GF(2) product A*B -> Q=A, R=0; plus random D in 0..31 against a bench reference model.
